// File: rtl/multi_alarm_ctrl.sv
// multi_alarm_ctrl: multi-slot BCD alarm sequencer with snooze,
// ring timeout, snooze limit and lowest-index arbitration.
module multi_alarm_ctrl #(
  parameter int NUM_ALARMS = 4,
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_MIN = 5,
  parameter int MAX_SNOOZE = 3,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  ac_clk,
  input  logic                  ac_rst_n,
  input  logic                  sec_tick,
  input  logic [15:0]           clock_val,
  input  logic                  master_en,
  input  logic                  wr_en,
  input  logic [IW-1:0]         wr_idx,
  input  logic [15:0]           wr_time,
  input  logic                  wr_slot_en,
  input  logic                  snooze,
  input  logic                  dismiss,
  output logic                  ring,
  output logic [IW-1:0]         active_idx,
  output logic [3:0]            snooze_cnt,
  output logic [1:0]            state_out,
  output logic [NUM_ALARMS-1:0] slot_en
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_RING = 2'b01;
  localparam logic [1:0] S_SNZ  = 2'b10;

  localparam logic [7:0] RS = 8'(RING_SEC);
  localparam logic [5:0] SM = 6'(SNOOZE_MIN);
  localparam logic [3:0] MS = 4'(MAX_SNOOZE);

  logic [15:0]           slot_time [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] slot_en_q;
  logic [15:0]           prev_clock;

  logic [1:0]    state;
  logic [1:0]    state_nxt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic [3:0]    scnt;
  logic [3:0]    scnt_nxt;
  logic [7:0]    sec_cnt;
  logic [7:0]    sec_nxt;
  logic [5:0]    min_cnt;
  logic [5:0]    min_nxt;
  logic          ring_q;

  logic          min_evt;
  logic          hit;
  logic [IW-1:0] win;
  logic          wr_ok;
  logic          cancel;
  logic          can_snz;
  logic [7:0]    sec_inc;
  logic [5:0]    min_inc;
  logic          timeout;

  assign min_evt = (prev_clock != clock_val);
  assign wr_ok   = wr_en && (int'(wr_idx) < NUM_ALARMS);
  assign cancel  = wr_ok && (wr_idx == idx) && !wr_slot_en;
  assign can_snz = (scnt < MS);
  assign sec_inc = (sec_cnt == 8'hFF) ? sec_cnt : sec_cnt + 8'd1;
  assign min_inc = (min_cnt == 6'h3F) ? min_cnt : min_cnt + 6'd1;
  assign timeout = sec_tick && (sec_inc >= RS);

  // Lowest-index enabled slot whose time equals the running clock.
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
      if (slot_en_q[i] && (slot_time[i] == clock_val)) begin
        hit = 1'b1;
        win = IW'(i);
      end
    end
  end

  // Sequencer next-state: kill conditions first, then buttons, then timers.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    scnt_nxt  = scnt;
    sec_nxt   = sec_cnt;
    min_nxt   = min_cnt;
    if (!master_en) begin
      state_nxt = S_IDLE;
      scnt_nxt  = '0;
      sec_nxt   = '0;
      min_nxt   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          scnt_nxt = '0;
          sec_nxt  = '0;
          min_nxt  = '0;
          if (min_evt && hit) begin
            state_nxt = S_RING;
            idx_nxt   = win;
          end
        end
        S_RING: begin
          if (cancel || dismiss) begin
            state_nxt = S_IDLE;
            scnt_nxt  = '0;
            sec_nxt   = '0;
          end else if (snooze && can_snz) begin
            state_nxt = S_SNZ;
            scnt_nxt  = scnt + 4'd1;
            sec_nxt   = '0;
            min_nxt   = '0;
          end else if (timeout) begin
            sec_nxt = '0;
            min_nxt = '0;
            if (can_snz) begin
              state_nxt = S_SNZ;
              scnt_nxt  = scnt + 4'd1;
            end else begin
              state_nxt = S_IDLE;
              scnt_nxt  = '0;
            end
          end else if (sec_tick) begin
            sec_nxt = sec_inc;
          end
        end
        S_SNZ: begin
          if (cancel || dismiss) begin
            state_nxt = S_IDLE;
            scnt_nxt  = '0;
            min_nxt   = '0;
          end else if (min_evt) begin
            if (min_inc >= SM) begin
              state_nxt = S_RING;
              sec_nxt   = '0;
              min_nxt   = '0;
            end else begin
              min_nxt = min_inc;
            end
          end
        end
        default: begin
          state_nxt = S_IDLE;
          scnt_nxt  = '0;
          sec_nxt   = '0;
          min_nxt   = '0;
        end
      endcase
    end
  end

  // Sequencer state, counters and the delayed ring decode.
  always_ff @(posedge ac_clk or negedge ac_rst_n) begin
    if (!ac_rst_n) begin
      state      <= S_IDLE;
      idx        <= '0;
      scnt       <= '0;
      sec_cnt    <= '0;
      min_cnt    <= '0;
      ring_q     <= 1'b0;
      prev_clock <= 16'h0000;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      scnt       <= scnt_nxt;
      sec_cnt    <= sec_nxt;
      min_cnt    <= min_nxt;
      ring_q     <= (state == S_RING);
      prev_clock <= clock_val;
    end
  end

  // Slot table; out-of-range indices are dropped.
  always_ff @(posedge ac_clk or negedge ac_rst_n) begin
    if (!ac_rst_n) begin
      slot_en_q <= '0;
      for (int i = 0; i < NUM_ALARMS; i++) begin
        slot_time[i] <= 16'h0000;
      end
    end else if (wr_ok) begin
      slot_time[wr_idx] <= wr_time;
      slot_en_q[wr_idx] <= wr_slot_en;
    end
  end

  assign ring       = ring_q;
  assign active_idx = idx;
  assign snooze_cnt = scnt;
  assign state_out  = state;
  assign slot_en    = slot_en_q;

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// tb_multi_alarm_ctrl: directed stimulus, per-cycle model compare
// and hand-computed literal checks for multi_alarm_ctrl.
module tb_multi_alarm_ctrl;

  localparam int NA  = 6;
  localparam int RS  = 4;
  localparam int SM  = 5;
  localparam int MS  = 3;
  localparam int IW  = 3;

  logic          ac_clk = 1'b0;
  logic          ac_rst_n;
  logic          sec_tick;
  logic [15:0]   clock_val;
  logic          master_en;
  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [15:0]   wr_time;
  logic          wr_slot_en;
  logic          snooze;
  logic          dismiss;
  logic          ring;
  logic [IW-1:0] active_idx;
  logic [3:0]    snooze_cnt;
  logic [1:0]    state_out;
  logic [NA-1:0] slot_en;

  int tests = 0;
  int fails = 0;

  multi_alarm_ctrl #(
    .NUM_ALARMS(NA),
    .RING_SEC(RS),
    .SNOOZE_MIN(SM),
    .MAX_SNOOZE(MS)
  ) dut (
    .ac_clk(ac_clk),
    .ac_rst_n(ac_rst_n),
    .sec_tick(sec_tick),
    .clock_val(clock_val),
    .master_en(master_en),
    .wr_en(wr_en),
    .wr_idx(wr_idx),
    .wr_time(wr_time),
    .wr_slot_en(wr_slot_en),
    .snooze(snooze),
    .dismiss(dismiss),
    .ring(ring),
    .active_idx(active_idx),
    .snooze_cnt(snooze_cnt),
    .state_out(state_out),
    .slot_en(slot_en)
  );

  always #5 ac_clk = ~ac_clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 0 idle, 1 ringing, 2 snoozed
  int m_st;
  int m_idx;
  int m_sc;
  int m_sec;
  int m_min;
  int m_ring;
  int m_prev;
  int m_t [NA];
  bit m_en [NA];

  always @(posedge ac_clk or negedge ac_rst_n) begin : model
    int st, ix, sc, sec, mn, win;
    bit evt, cancel, wr_ok;
    if (!ac_rst_n) begin
      m_st <= 0; m_idx <= 0; m_sc <= 0; m_sec <= 0;
      m_min <= 0; m_ring <= 0; m_prev <= 0;
      for (int i = 0; i < NA; i++) begin
        m_t[i] <= 0;
        m_en[i] <= 1'b0;
      end
    end else begin
      st = m_st; ix = m_idx; sc = m_sc; sec = m_sec; mn = m_min;
      evt = (int'(clock_val) != m_prev);
      wr_ok = wr_en && (int'(wr_idx) < NA);
      cancel = wr_ok && (int'(wr_idx) == m_idx) && !wr_slot_en;
      win = -1;
      for (int i = NA - 1; i >= 0; i--)
        if (m_en[i] && m_t[i] == int'(clock_val)) win = i;
      if (!master_en) begin
        st = 0;
      end else if (m_st == 0) begin
        if (evt && win >= 0) begin
          st = 1; ix = win; sec = 0;
        end
      end else if (m_st == 1) begin
        if (cancel || dismiss) st = 0;
        else if (snooze && sc < MS) begin
          st = 2; sc = sc + 1; mn = 0;
        end else if (sec_tick && (sec + 1 >= RS)) begin
          if (sc < MS) begin
            st = 2; sc = sc + 1; mn = 0;
          end else st = 0;
        end else if (sec_tick) sec = (sec < 255) ? sec + 1 : 255;
      end else begin
        if (cancel || dismiss) st = 0;
        else if (evt) begin
          if (mn + 1 >= SM) begin
            st = 1; sec = 0;
          end else mn = mn + 1;
        end
      end
      if (st == 0) begin
        sc = 0; sec = 0; mn = 0;
      end
      m_ring <= (m_st == 1) ? 1 : 0;
      m_st <= st; m_idx <= ix; m_sc <= sc; m_sec <= sec; m_min <= mn;
      m_prev <= int'(clock_val);
      if (wr_ok) begin
        m_t[wr_idx] <= int'(wr_time);
        m_en[wr_idx] <= wr_slot_en;
      end
    end
  end

  // Every-cycle compare, sampled 2 ns after the active edge.
  always begin
    @(posedge ac_clk);
    #2;
    if (ac_rst_n) begin
      int en_vec;
      en_vec = 0;
      for (int i = 0; i < NA; i++) if (m_en[i]) en_vec |= (1 << i);
      chk("m_state", int'(state_out), m_st);
      chk("m_ring", int'(ring), m_ring);
      chk("m_snzcnt", int'(snooze_cnt), m_sc);
      chk("m_sloten", int'(slot_en), en_vec);
      if (m_st != 0) chk("m_idx", int'(active_idx), m_idx);
    end
  end

  function automatic logic [15:0] bcd_inc(input logic [15:0] t);
    logic [15:0] r;
    r = t;
    if (t[3:0] < 4'd9) r[3:0] = t[3:0] + 4'd1;
    else if (t[7:4] < 4'd5) begin
      r[7:4] = t[7:4] + 4'd1;
      r[3:0] = 4'd0;
    end else begin
      r[7:0] = 8'h00;
      r[11:8] = t[11:8] + 4'd1;
    end
    return r;
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge ac_clk);
  endtask

  task automatic wr(input int idx, input logic [15:0] t, input logic en);
    wr_en = 1'b1; wr_idx = IW'(idx); wr_time = t; wr_slot_en = en;
    cyc(1);
    wr_en = 1'b0;
  endtask

  task automatic press(input logic s, input logic d);
    snooze = s; dismiss = d;
    cyc(1);
    snooze = 1'b0; dismiss = 1'b0;
  endtask

  task automatic tick();
    sec_tick = 1'b1;
    cyc(1);
    sec_tick = 1'b0;
    cyc(1);
  endtask

  task automatic minutes(input int n);
    for (int i = 0; i < n; i++) begin
      clock_val = bcd_inc(clock_val);
      cyc(1);
    end
  endtask

  task automatic arm_0900();
    clock_val = 16'h0901;
    cyc(1);
    clock_val = 16'h0900;
    cyc(2);
  endtask

  initial begin
    ac_rst_n = 1'b0; sec_tick = 1'b0; clock_val = 16'h0000;
    master_en = 1'b0; wr_en = 1'b0; wr_idx = '0; wr_time = '0;
    wr_slot_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    cyc(3);
    ac_rst_n = 1'b1;
    cyc(1);
    chk("rst_ring", int'(ring), 0);
    chk("rst_state", int'(state_out), 0);
    chk("rst_sloten", int'(slot_en), 0);
    chk("rst_snz", int'(snooze_cnt), 0);
    master_en = 1'b1;

    wr(1, 16'h0730, 1'b1);
    chk("wr_slot1", int'(slot_en), 'b000010);
    clock_val = 16'h0729;
    cyc(1);
    clock_val = 16'h0730;
    cyc(1);
    chk("trig_state", int'(state_out), 1);
    chk("trig_ring_lat", int'(ring), 0);
    cyc(1);
    chk("trig_ring", int'(ring), 1);
    chk("trig_idx", int'(active_idx), 1);
    press(1'b0, 1'b1);
    cyc(3);
    chk("no_retrig", int'(state_out), 0);
    chk("no_retrig_ring", int'(ring), 0);

    wr(0, 16'h0800, 1'b1);
    wr(2, 16'h0800, 1'b1);
    clock_val = 16'h0800;
    cyc(2);
    chk("prio_idx", int'(active_idx), 0);
    chk("prio_ring", int'(ring), 1);
    press(1'b0, 1'b1);
    cyc(3);
    chk("slot2_silent", int'(state_out), 0);

    wr(3, 16'h0900, 1'b1);
    clock_val = 16'h0900;
    cyc(2);
    chk("s3_idx", int'(active_idx), 3);
    for (int k = 1; k <= MS; k++) begin
      press(1'b1, 1'b0);
      chk("snz_state", int'(state_out), 2);
      chk("snz_cnt", int'(snooze_cnt), k);
      cyc(1);
      chk("snz_ring", int'(ring), 0);
      minutes(SM - 1);
      chk("snz_wait", int'(state_out), 2);
      minutes(1);
      chk("snz_wake", int'(state_out), 1);
      cyc(1);
      chk("snz_wake_ring", int'(ring), 1);
    end
    press(1'b1, 1'b0);
    cyc(1);
    chk("snz_limit_state", int'(state_out), 1);
    chk("snz_limit_cnt", int'(snooze_cnt), 3);
    chk("snz_limit_ring", int'(ring), 1);
    press(1'b0, 1'b1);
    cyc(1);

    clock_val = 16'h0900;
    cyc(2);
    for (int k = 1; k <= MS; k++) begin
      repeat (RS - 1) tick();
      chk("to_early", int'(state_out), 1);
      tick();
      chk("to_state", int'(state_out), 2);
      chk("to_cnt", int'(snooze_cnt), k);
      minutes(SM);
    end
    chk("to_last_ring", int'(state_out), 1);
    repeat (RS) tick();
    chk("to_expire", int'(state_out), 0);
    chk("to_expire_ring", int'(ring), 0);
    chk("to_expire_cnt", int'(snooze_cnt), 0);

    clock_val = 16'h0900;
    cyc(2);
    press(1'b1, 1'b1);
    chk("both_state", int'(state_out), 0);
    chk("both_cnt", int'(snooze_cnt), 0);
    arm_0900();
    repeat (RS - 1) tick();
    sec_tick = 1'b1;
    press(1'b1, 1'b0);
    sec_tick = 1'b0;
    chk("tick_snz_state", int'(state_out), 2);
    chk("tick_snz_cnt", int'(snooze_cnt), 1);
    master_en = 1'b0;
    cyc(1);
    chk("men_off", int'(state_out), 0);
    master_en = 1'b1;

    arm_0900();
    chk("cancel_pre", int'(state_out), 1);
    wr(3, 16'h1234, 1'b1);
    chk("time_only", int'(state_out), 1);
    wr(3, 16'h1234, 1'b0);
    chk("cancel", int'(state_out), 0);
    chk("cancel_en", int'(slot_en), 'b000111);
    wr(6, 16'h0900, 1'b1);
    wr(7, 16'h0900, 1'b1);
    chk("oob_wr", int'(slot_en), 'b000111);

    wr(3, 16'h0900, 1'b1);
    arm_0900();
    cyc(1);
    chk("pre_rst_ring", int'(ring), 1);
    ac_rst_n = 1'b0;
    #1;
    chk("async_ring", int'(ring), 0);
    chk("async_sloten", int'(slot_en), 0);
    chk("async_state", int'(state_out), 0);
    cyc(2);
    ac_rst_n = 1'b1;
    cyc(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
